// File: rtl/uart_hex_pkg.sv
// uart_hex_tx shared types: FSM state encoding, ASCII constants and nibble-to-ASCII helper.
// The prefix states exist only when UART_HEX_PREFIX_EN is defined.
package uart_hex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef UART_HEX_PREFIX_EN
    ST_PREFIX0,
    ST_PREFIX1,
`endif
    ST_DIGIT,
    ST_CR,
    ST_LF
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_X       = 8'h78;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_ZERO + {4'h0, nib};
    else             return ASCII_UPPER_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_hex_tx.sv
// Prints one word per handshake as uppercase hex + EOL onto a byte stream; first byte 1 cycle after accept,
// all outputs registered, stalls indefinitely on m_axis_tready low. UART_HEX_PREFIX_EN adds a "0x" prefix.
module uart_hex_tx
  import uart_hex_pkg::*;
#(
  parameter int WORD_NIBBLES = 8,
  parameter bit EOL_CRLF     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*WORD_NIBBLES-1:0] s_word_tdata,
  input  logic                      s_word_tvalid,
  output logic                      s_word_tready,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      busy
);

  localparam int IDX_W = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [4*WORD_NIBBLES-1:0] word_q, word_d;
  logic                      tvalid_q, tvalid_d;
  logic [7:0]                tdata_q, tdata_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      byte_hs;
  logic [3:0]                nib_d;

  assign byte_hs = tvalid_q & m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      word_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= 8'h00;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (s_word_tvalid && ready_q) begin
          word_d  = s_word_tdata;
          idx_d   = IDX_W'(WORD_NIBBLES - 1);
`ifdef UART_HEX_PREFIX_EN
          state_d = ST_PREFIX0;
`else
          state_d = ST_DIGIT;
`endif
        end
      end
`ifdef UART_HEX_PREFIX_EN
      ST_PREFIX0: if (byte_hs) state_d = ST_PREFIX1;
      ST_PREFIX1: if (byte_hs) state_d = ST_DIGIT;
`endif
      ST_DIGIT: begin
        if (byte_hs) begin
          if (idx_q != '0) idx_d   = idx_q - 1'b1;
          else             state_d = EOL_CRLF ? ST_CR : ST_LF;
        end
      end
      ST_CR:   if (byte_hs) state_d = ST_LF;
      ST_LF:   if (byte_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without adding latency.
  always_comb begin
    tvalid_d = (state_d != ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    ready_d  = (state_d == ST_IDLE);
    nib_d    = 4'(word_d >> {idx_d, 2'b00});
    tdata_d  = 8'h00;
    case (state_d)
`ifdef UART_HEX_PREFIX_EN
      ST_PREFIX0: tdata_d = ASCII_ZERO;
      ST_PREFIX1: tdata_d = ASCII_X;
`endif
      ST_DIGIT:   tdata_d = nib2ascii(nib_d);
      ST_CR:      tdata_d = ASCII_CR;
      ST_LF:      tdata_d = ASCII_LF;
      default:    tdata_d = 8'h00;
    endcase
  end

  assign s_word_tready = ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Randomised scoreboard bench for uart_hex_tx (default build, or with UART_HEX_PREFIX_EN defined).
module tb_uart_hex_tx;

`ifdef UART_HEX_PREFIX_EN
  localparam bit PFX = 1'b1;
`else
  localparam bit PFX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        busy;

  logic [7:0]  d2_wdat;
  logic        d2_wvld;
  logic        d2_wrdy;
  logic [7:0]  d2_dat;
  logic        d2_vld;
  logic        d2_trdy = 1'b1;
  logic        d2_busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          c_rst;
  bit          rdy_rand = 1'b0;

  logic [7:0]  exp_q[$];
  bit          last_q[$];
  logic [7:0]  cap_q[$];
  int          hs_cyc[$];
  int          acc_cyc[$];
  logic [7:0]  q2[$];
  bit          in_line = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_dat = 8'h00;
  int          bytes_seen = 0;

  always #5 clk = ~clk;

  uart_hex_tx dut (
    .clk(clk), .rst_n(rst_n),
    .s_word_tdata(s_tdata), .s_word_tvalid(s_tvalid), .s_word_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .busy(busy)
  );

  uart_hex_tx #(.WORD_NIBBLES(2), .EOL_CRLF(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_word_tdata(d2_wdat), .s_word_tvalid(d2_wvld), .s_word_tready(d2_wrdy),
    .m_axis_tdata(d2_dat), .m_axis_tvalid(d2_vld), .m_axis_tready(d2_trdy),
    .busy(d2_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference text: optional "0x", hex digits MSB first, then CR LF or LF.
  function automatic int line_len(input int nib, input bit crlf);
    return (PFX ? 2 : 0) + nib + (crlf ? 2 : 1);
  endfunction

  function automatic logic [7:0] exp_byte(input logic [63:0] w, input int nib, input bit crlf, input int k);
    int p;
    int i;
    int n;
    p = PFX ? 2 : 0;
    if (k < p) return (k == 0) ? 8'h30 : 8'h78;
    if (k < p + nib) begin
      i = nib - 1 - (k - p);
      n = int'((w >> (4 * i)) & 64'hF);
      return (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
    end
    if (crlf && k == p + nib) return 8'h0D;
    return 8'h0A;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_rst <= 0;
    else        c_rst <= c_rst + 1;
  end

  always @(posedge clk) begin
    #1;
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    int len;
    logic [7:0] e;
    bit l;
    if (!rst_n) begin
      exp_q.delete();
      last_q.delete();
      in_line    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("busy", busy, in_line);
      if (c_rst >= 1) check("word_rdy", s_tready, !in_line);
      if (prev_stall) begin
        check("vld_hold", m_tvalid, 1);
        check("dat_hold", m_tdata, prev_dat);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("spurious_byte", m_tvalid, 0);
        else begin
          e = exp_q.pop_front();
          l = last_q.pop_front();
          check("byte", m_tdata, e);
          cap_q.push_back(m_tdata);
          hs_cyc.push_back(cyc);
          bytes_seen++;
          if (l) in_line = 1'b0;
        end
      end
      if (s_tvalid && s_tready) begin
        acc_cyc.push_back(cyc);
        len = line_len(8, 1'b1);
        for (int k = 0; k < len; k++) begin
          exp_q.push_back(exp_byte(64'(s_tdata), 8, 1'b1, k));
          last_q.push_back(k == len - 1);
        end
        in_line = 1'b1;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_dat   = m_tdata;
    end
  end

  always @(negedge clk) if (rst_n && d2_vld && d2_trdy) q2.push_back(d2_dat);

  task automatic send_word(input logic [31:0] w);
    bit got;
    got = 1'b0;
    s_tdata  = w;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (s_tready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tdata  = $urandom;
    check("accept_timeout", got, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_line) break;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    int a0;
    int b0;
    int len;
    logic [7:0] lit[$];
    s_tvalid = 1'b0;
    s_tdata  = '0;
    d2_wvld  = 1'b0;
    d2_wdat  = '0;
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_word_rdy", s_tready, 0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, full throughput, 1-cycle latency
    len = line_len(8, 1'b1);
    n0 = hs_cyc.size();
    send_word(32'h1234ABCD);
    wait_drain();
    check("t1_count", hs_cyc.size() - n0, len);
    check("t1_latency", hs_cyc[n0] - acc_cyc[acc_cyc.size() - 1], 1);
    for (int i = 1; i < len; i++) check("t1_consecutive", hs_cyc[n0 + i] - hs_cyc[n0], i);

    // Back-to-back words: one idle cycle, first byte 2 cycles after LF
    n0 = hs_cyc.size();
    a0 = acc_cyc.size();
    send_word(32'h00000000);
    send_word(32'hFFFFFFFF);
    wait_drain();
    check("t2_gap_accept", acc_cyc[a0 + 1] - hs_cyc[n0 + len - 1], 1);
    check("t2_gap_byte", hs_cyc[n0 + len] - hs_cyc[n0 + len - 1], 2);

    // Literal anchor for 0x0000000A
    n0 = cap_q.size();
    send_word(32'h0000000A);
    wait_drain();
    if (PFX) begin lit.push_back(8'h30); lit.push_back(8'h78); end
    for (int i = 0; i < 7; i++) lit.push_back(8'h30);
    lit.push_back(8'h41); lit.push_back(8'h0D); lit.push_back(8'h0A);
    check("lit_len", cap_q.size() - n0, lit.size());
    for (int i = 0; i < lit.size() && n0 + i < cap_q.size(); i++) check("lit_byte", cap_q[n0 + i], lit[i]);

    // Random words under random backpressure
    rdy_rand = 1'b1;
    for (int w = 0; w < 100; w++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      send_word($urandom);
    end
    wait_drain();
    rdy_rand = 1'b0;

    // Reset mid-digit
    b0 = bytes_seen;
    send_word(32'hDEADBEEF);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (bytes_seen >= b0 + 3) break;
    end
    check("mid_bytes", bytes_seen - b0, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", m_tvalid, 0);
    check("arst_tdata", m_tdata, 8'h00);
    check("arst_busy", busy, 0);
    check("arst_word_rdy", s_tready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n0 = cap_q.size();
    send_word(32'h00000001);
    wait_drain();
    check("post_rst_len", cap_q.size() - n0, len);

    // Narrow instance: WORD_NIBBLES=2, LF only
    d2_wdat = 8'h5F;
    d2_wvld = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d2_wrdy) break;
    end
    @(posedge clk); #1;
    d2_wvld = 1'b0;
    repeat (20) @(posedge clk);
    check("d2_len", q2.size(), line_len(2, 1'b0));
    for (int k = 0; k < line_len(2, 1'b0) && k < q2.size(); k++)
      check("d2_byte", q2[k], exp_byte(64'h5F, 2, 1'b0, k));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
